// File: rtl/seg_scan_reader_if.sv
// Bundle for the multiplexed 7-segment display bus and the decoded readback.
// The master drives the display lines; the slave (the reader) returns the decoded frame.
interface seg_scan_reader_if #(
    parameter int NDIG = 4
);
    logic [7:0]        seg_n;
    logic [NDIG-1:0]   dig_n;
    logic [4*NDIG-1:0] digits_out;
    logic [NDIG-1:0]   dp_out;
    logic              frame_valid;
    logic              frame_err;
    logic              bad_pattern;
    logic              sel_err;

    modport master (
        output seg_n, dig_n,
        input  digits_out, dp_out, frame_valid, frame_err, bad_pattern, sel_err
    );

    modport slave (
        input  seg_n, dig_n,
        output digits_out, dp_out, frame_valid, frame_err, bad_pattern, sel_err
    );
endinterface

// File: rtl/seg_scan_reader.sv
// Reads a multiplexed active-low 7-segment bus back into per-digit 4-bit codes, one frame per scan.
// Define SEG_READER_DP_EN to also capture each digit's decimal point; otherwise dp is ignored.
module seg_scan_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_reader_if.slave bus
);
    localparam int            CW      = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_e;

    state_e                 state_d, state_q;
    logic [7:0]             seg_d, seg_q;
    logic [NDIG-1:0]        dig_d, dig_q;
    logic [CW-1:0]          cnt_d, cnt_q;
    logic [NDIG-1:0][3:0]   slot_d, slot_q, digits_q;
    logic [NDIG-1:0]        seen_d, seen_q, wr_mask;
    logic                   acc_d, acc_q, ferr_q, fv_q, bad_d, bad_q, sel_d, sel_q;
    logic                   blank_nxt, chg, capture, onehot, frame_done;
    logic [4:0]             dec;

    // {recognised, code}; unrecognised patterns read back as blank.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = {1'b1, 4'h0};
            7'b1001111: decode = {1'b1, 4'h1};
            7'b0010010: decode = {1'b1, 4'h2};
            7'b0000110: decode = {1'b1, 4'h3};
            7'b1001100: decode = {1'b1, 4'h4};
            7'b0100100: decode = {1'b1, 4'h5};
            7'b0100000: decode = {1'b1, 4'h6};
            7'b0001111: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0000100: decode = {1'b1, 4'h9};
            7'b1111111: decode = {1'b1, 4'hA};
            7'b1111110: decode = {1'b1, 4'hB};
            7'b0110001: decode = {1'b1, 4'hC};
            7'b1000010: decode = {1'b1, 4'hD};
            7'b0110000: decode = {1'b1, 4'hE};
            7'b0111000: decode = {1'b1, 4'hF};
            default:    decode = {1'b0, 4'hA};
        endcase
    endfunction

`ifdef SEG_READER_DP_EN
    assign seg_d = bus.seg_n;
`else
    // dp line is forced inactive so it never disturbs the stability compare.
    assign seg_d = {bus.seg_n[7:1], 1'b1};
`endif
    assign dig_d = bus.dig_n;

    // cnt_q counts how many consecutive registered samples matched their predecessor.
    assign blank_nxt = &dig_d;
    assign chg       = {seg_d, dig_d} != {seg_q, dig_q};

    always_comb begin
        cnt_d = cnt_q;
        if (blank_nxt || chg)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!blank_nxt) state_d = SETTLE;
            end
            SETTLE: begin
                if (blank_nxt) begin
                    state_d = IDLE;
                end else if (!chg && cnt_d == CNT_MAX) begin
                    state_d = CAPTURED;
                    capture = 1'b1;
                end
            end
            CAPTURED: begin
                if (blank_nxt)  state_d = IDLE;
                else if (chg)   state_d = SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        onehot     = $onehot(~dig_q);
        dec        = decode(seg_q[7:1]);
        wr_mask    = (capture && onehot) ? ~dig_q : '0;
        sel_d      = capture && !onehot;
        bad_d      = capture && onehot && !dec[4];
        seen_d     = seen_q | wr_mask;
        acc_d      = acc_q | bad_d;
        frame_done = &seen_d;
        slot_d     = slot_q;
        for (int i = 0; i < NDIG; i++)
            if (wr_mask[i]) slot_d[i] = dec[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            seg_q    <= '1;
            dig_q    <= '1;
            cnt_q    <= '0;
            slot_q   <= '0;
            seen_q   <= '0;
            acc_q    <= 1'b0;
            digits_q <= '0;
            ferr_q   <= 1'b0;
            fv_q     <= 1'b0;
            bad_q    <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            fv_q    <= frame_done;
            bad_q   <= bad_d;
            sel_q   <= sel_d;
            if (frame_done) begin
                digits_q <= slot_d;
                ferr_q   <= acc_d;
                seen_q   <= '0;
                acc_q    <= 1'b0;
            end else begin
                seen_q   <= seen_d;
                acc_q    <= acc_d;
            end
        end
    end

`ifdef SEG_READER_DP_EN
    logic [NDIG-1:0] dps_d, dps_q, dp_q;

    always_comb begin
        dps_d = dps_q;
        for (int i = 0; i < NDIG; i++)
            if (wr_mask[i]) dps_d[i] = ~seg_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dps_q <= '0;
            dp_q  <= '0;
        end else begin
            dps_q <= dps_d;
            if (frame_done) dp_q <= dps_d;
        end
    end

    assign bus.dp_out = dp_q;
`else
    assign bus.dp_out = '0;
`endif

    assign bus.digits_out  = digits_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = ferr_q;
    assign bus.bad_pattern = bad_q;
    assign bus.sel_err     = sel_q;
endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: scan-level reference model checked every cycle,
// plus literal expectations per scenario.
module tb_seg_scan_reader;
    localparam int NDIG = 4;
    localparam int S    = 4;
`ifdef SEG_READER_DP_EN
    localparam logic [7:0] MASK = 8'hFF;
`else
    localparam logic [7:0] MASK = 8'hFE;
`endif
    localparam logic [6:0] PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111111, 7'b1111110,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_reader_if #(.NDIG(NDIG)) bus();
    seg_scan_reader #(.NDIG(NDIG), .STABLE_CYC(S)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int fv_cnt = 0, bad_cnt = 0, sel_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a digit is captured once its pin value has been held S+1 cycles.
    logic [NDIG+7:0] last_key, key;
    bit              have_last = 0;
    int              run = 0;
    logic [3:0]      m_slot [NDIG];
    bit              m_dps  [NDIG];
    logic [NDIG-1:0] m_seen;
    bit              m_acc, m_live = 0;
    logic [15:0]     e_digits;
    logic [3:0]      e_dp;
    bit              e_fv, e_ferr, e_bad, e_sel;

    always @(posedge clk) begin : model
        bit ok;
        logic [3:0] code;
        int idx, nz;
        e_fv = 0; e_bad = 0; e_sel = 0; m_live = 1;
        if (rst) begin
            have_last = 0; run = 0; m_seen = '0; m_acc = 0;
            e_digits = '0; e_dp = '0; e_ferr = 0;
            for (int i = 0; i < NDIG; i++) begin m_slot[i] = '0; m_dps[i] = 0; end
        end else begin
            key = {bus.seg_n & MASK, bus.dig_n};
            if (have_last && key == last_key) run = (run < 1000) ? run + 1 : run;
            else run = 1;
            last_key = key; have_last = 1;
            if (bus.dig_n != '1 && run == S + 1) begin
                nz = NDIG - $countones(bus.dig_n);
                if (nz > 1) e_sel = 1;
                else begin
                    idx = 0;
                    for (int i = 0; i < NDIG; i++) if (!bus.dig_n[i]) idx = i;
                    ok = 0; code = 4'hA;
                    for (int k = 0; k < 16; k++)
                        if (PAT[k] == bus.seg_n[7:1]) begin ok = 1; code = k[3:0]; end
                    m_slot[idx] = code;
`ifdef SEG_READER_DP_EN
                    m_dps[idx] = ~bus.seg_n[0];
`endif
                    m_seen[idx] = 1'b1;
                    if (!ok) begin e_bad = 1; m_acc = 1; end
                    if (&m_seen) begin
                        for (int i = 0; i < NDIG; i++) begin
                            e_digits[4*i +: 4] = m_slot[i];
                            e_dp[i] = m_dps[i];
                        end
                        e_ferr = m_acc; e_fv = 1; m_seen = '0; m_acc = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (m_live) begin
            chk("digits_out",  32'(bus.digits_out),  32'(e_digits));
            chk("dp_out",      32'(bus.dp_out),      32'(e_dp));
            chk("frame_valid", 32'(bus.frame_valid), 32'(e_fv));
            chk("frame_err",   32'(bus.frame_err),   32'(e_ferr));
            chk("bad_pattern", 32'(bus.bad_pattern), 32'(e_bad));
            chk("sel_err",     32'(bus.sel_err),     32'(e_sel));
            if (bus.frame_valid === 1'b1) fv_cnt++;
            if (bus.bad_pattern === 1'b1) bad_cnt++;
            if (bus.sel_err === 1'b1)     sel_cnt++;
        end
    end

    task automatic hold(input logic [7:0] s, input logic [NDIG-1:0] d, input int n);
        bus.seg_n = s;
        bus.dig_n = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] p0, p1, p2, p3);
        hold(p0, 4'b1110, 8);
        hold(p1, 4'b1101, 8);
        hold(p2, 4'b1011, 8);
        hold(p3, 4'b0111, 8);
        hold(8'hFF, 4'b1111, 4);
    endtask

    initial begin : stim
        int fv0, bad0, sel0;
        bus.seg_n = 8'hFF;
        bus.dig_n = '1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset digits", 32'(bus.digits_out), 32'h0);
        chk("reset valid",  32'(bus.frame_valid), 32'h0);
        chk("reset err",    32'(bus.frame_err), 32'h0);
        rst = 1'b0;

        // Scan 1,2,3,4 and pin the completion latency on the last digit.
        fv0 = fv_cnt; bad0 = bad_cnt;
        hold(8'h9F, 4'b1110, 8);
        hold(8'h25, 4'b1101, 8);
        hold(8'h0D, 4'b1011, 8);
        hold(8'h99, 4'b0111, S);
        chk("t1 valid before latency", 32'(bus.frame_valid), 32'h0);
        @(negedge clk);
        chk("t1 valid at latency", 32'(bus.frame_valid), 32'h1);
        chk("t1 digits at latency", 32'(bus.digits_out), 32'h4321);
        hold(8'h99, 4'b0111, 8 - S - 1);
        hold(8'hFF, 4'b1111, 4);
        chk("t1 frames", 32'(fv_cnt - fv0), 32'd1);
        chk("t1 frame_err", 32'(bus.frame_err), 32'h0);
        chk("t1 bad", 32'(bad_cnt - bad0), 32'd0);

        // Two-cycle glitch inside digit 2's dwell.
        fv0 = fv_cnt; bad0 = bad_cnt;
        hold(8'h9F, 4'b1110, 8);
        hold(8'h25, 4'b1101, 8);
        hold(8'h0D, 4'b1011, 3);
        hold(8'h01, 4'b1011, 2);
        hold(8'h0D, 4'b1011, 8);
        hold(8'h99, 4'b0111, 8);
        hold(8'hFF, 4'b1111, 4);
        chk("t2 frames", 32'(fv_cnt - fv0), 32'd1);
        chk("t2 digits", 32'(bus.digits_out), 32'h4321);
        chk("t2 bad", 32'(bad_cnt - bad0), 32'd0);

        // Illegal pattern on digit 1, then a clean frame.
        fv0 = fv_cnt; bad0 = bad_cnt;
        scan(8'h9F, 8'h55, 8'h0D, 8'h99);
        chk("t3 frames", 32'(fv_cnt - fv0), 32'd1);
        chk("t3 bad", 32'(bad_cnt - bad0), 32'd1);
        chk("t3 digits", 32'(bus.digits_out), 32'h43A1);
        chk("t3 frame_err", 32'(bus.frame_err), 32'h1);
        scan(8'h9F, 8'h25, 8'h0D, 8'h99);
        chk("t3 clean digits", 32'(bus.digits_out), 32'h4321);
        chk("t3 clean frame_err", 32'(bus.frame_err), 32'h0);

        // Two selects low at once.
        fv0 = fv_cnt; sel0 = sel_cnt;
        hold(8'h25, 4'b0011, 6);
        hold(8'hFF, 4'b1111, 4);
        chk("t4 sel pulses", 32'(sel_cnt - sel0), 32'd1);
        chk("t4 frames", 32'(fv_cnt - fv0), 32'd0);
        chk("t4 digits", 32'(bus.digits_out), 32'h4321);

        // Reset after two captures, then a fresh full scan.
        hold(8'h03, 4'b1110, 8);
        hold(8'h01, 4'b1101, 8);
        rst = 1'b1;
        hold(8'hFF, 4'b1111, 2);
        rst = 1'b0;
        chk("t5 reset digits", 32'(bus.digits_out), 32'h0);
        chk("t5 reset err", 32'(bus.frame_err), 32'h0);
        fv0 = fv_cnt;
        hold(8'h09, 4'b1110, 8);
        hold(8'h01, 4'b1101, 8);
        hold(8'h1F, 4'b1011, 8);
        chk("t5 no early frame", 32'(fv_cnt - fv0), 32'd0);
        hold(8'h41, 4'b0111, 8);
        hold(8'hFF, 4'b1111, 4);
        chk("t5 frames", 32'(fv_cnt - fv0), 32'd1);
        chk("t5 digits", 32'(bus.digits_out), 32'h6789);

        // Digit 0 shows 0 with the decimal point lit.
        scan(8'h02, 8'h25, 8'h0D, 8'h99);
        chk("t6 digits", 32'(bus.digits_out), 32'h4320);
`ifdef SEG_READER_DP_EN
        chk("t6 dp_out", 32'(bus.dp_out), 32'h1);
`else
        chk("t6 dp_out", 32'(bus.dp_out), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
